// File: rtl/par_scheduler_pkg.sv
// Shared definitions for the partition scheduler: FSM state encoding,
// PE control encodings, phase encodings and a small phase->control helper.
package par_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LAUNCH = 3'd2,
      S_WAIT   = 3'd3,
      S_NEXT   = 3'd4,
      S_DRAIN  = 3'd5,
      S_DONE   = 3'd6
   } sched_state_e;

   localparam logic [1:0] CTRL_IDLE    = 2'd0;
   localparam logic [1:0] CTRL_SCATTER = 2'd1;
   localparam logic [1:0] CTRL_GATHER  = 2'd2;

   localparam logic PHASE_SCATTER = 1'b0;
   localparam logic PHASE_GATHER  = 1'b1;

   // PE work counters are registered, so its completion flag is stale for
   // this many cycles after a launch.
   localparam logic [1:0] WAIT_BLANK_CYC = 2'd2;

   function automatic logic [1:0] phase_to_ctrl(input logic phase);
      return (phase == PHASE_GATHER) ? CTRL_GATHER : CTRL_SCATTER;
   endfunction

endpackage

// File: rtl/sched_drain_timer.sv
// Drain timer: load arms it with DRAIN_CYC, count decrements it, and
// expire_o flags the last counted cycle of the drain window.
module sched_drain_timer
   import par_scheduler_pkg::*;
#(
   parameter int DRAIN_CYC = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic count_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(DRAIN_CYC + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DRAIN_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: reload on load, otherwise step down while counting.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (count_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expire_o = count_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/par_scheduler.sv
// Partition scheduler: walks one PE through scatter and gather phases over
// PAR_NUM partitions per phase, for up to num_iter iterations, stopping early
// when a gather phase updates no vertex.
// Optional feature macro: PAR_SKIP_INACTIVE_EN (skip launching inactive
// scatter partitions).
//
// Metadata handshake: meta_req is a valid-style request; meta_par_id and
// meta_phase are held stable while meta_req=1 and the request stays up until
// the cycle in which meta_valid=1, when the response is latched. meta_valid
// in any other state is ignored.
module par_scheduler
   import par_scheduler_pkg::*;
#(
   parameter int PAR_NUM   = 32,
   parameter int PAR_NUM_W = 5,
   parameter int DRAIN_CYC = 16,
   parameter int ITER_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ITER_W-1:0]    num_iter,
   output logic                 meta_req,
   output logic [PAR_NUM_W-1:0] meta_par_id,
   output logic                 meta_phase,
   input  logic                 meta_valid,
   input  logic [31:0]          meta_work_size,
   input  logic                 meta_active,
   output logic [1:0]           control,
   output logic                 new_par_start,
   output logic                 new_par_active,
   output logic [31:0]          work_size,
   input  logic                 par_complete_sig,
   input  logic                 pe_par_active,
   output logic                 busy,
   output logic                 done,
   output logic                 converged,
   output logic [ITER_W-1:0]    iter_cnt,
   output logic [2:0]           dbg_state
);

   localparam logic [PAR_NUM_W-1:0] LAST_PAR = PAR_NUM_W'(PAR_NUM - 1);
   localparam logic [ITER_W-1:0]    ITER_MAX = {ITER_W{1'b1}};

   sched_state_e         state_q, state_d;
   logic [PAR_NUM_W-1:0] par_q, par_d;
   logic                 phase_q, phase_d;
   logic [ITER_W-1:0]    num_iter_q, num_iter_d;
   logic [ITER_W-1:0]    iter_q, iter_d;
   logic [31:0]          ws_q, ws_d;
   logic                 act_q, act_d;
   logic [1:0]           blank_q, blank_d;
   logic                 seen_q, seen_d;
   logic                 conv_q, conv_d;

   logic                 drain_load, drain_count, drain_expire;
   logic                 running;
   logic                 seen_now;
   logic [ITER_W-1:0]    iter_inc;

   sched_drain_timer #(
      .DRAIN_CYC (DRAIN_CYC)
   ) u_drain (
      .clk_i    (clk),
      .rst_ni   (rst),
      .load_i   (drain_load),
      .count_i  (drain_count),
      .expire_o (drain_expire)
   );

   assign running  = (state_q != S_IDLE) && (state_q != S_DONE);
   assign seen_now = seen_q || pe_par_active;
   assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + ITER_W'(1);

   // Next-state logic and per-state strobes.
   always_comb begin
      state_d     = state_q;
      par_d       = par_q;
      phase_d     = phase_q;
      num_iter_d  = num_iter_q;
      iter_d      = iter_q;
      ws_d        = ws_q;
      act_d       = act_q;
      blank_d     = blank_q;
      seen_d      = seen_q;
      conv_d      = conv_q;
      drain_load  = 1'b0;
      drain_count = 1'b0;
      meta_req    = 1'b0;
      new_par_start = 1'b0;
      control     = running ? phase_to_ctrl(phase_q) : CTRL_IDLE;

      // Any updated vertex during gather keeps the run going.
      if (running && (phase_q == PHASE_GATHER) && pe_par_active) begin
         seen_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_iter_d = num_iter;
               iter_d     = '0;
               conv_d     = 1'b0;
               seen_d     = 1'b0;
               par_d      = '0;
               phase_d    = PHASE_SCATTER;
               state_d    = (num_iter == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            meta_req = 1'b1;
            if (meta_valid) begin
               ws_d  = meta_work_size;
               act_d = meta_active;
`ifdef PAR_SKIP_INACTIVE_EN
               if ((phase_q == PHASE_SCATTER) && !meta_active) state_d = S_NEXT;
               else                                            state_d = S_LAUNCH;
`else
               state_d = S_LAUNCH;
`endif
            end
         end
         S_LAUNCH: begin
            new_par_start = 1'b1;
            blank_d       = WAIT_BLANK_CYC;
            state_d       = S_WAIT;
         end
         S_WAIT: begin
            if (blank_q != 2'd0) begin
               blank_d = blank_q - 2'd1;
            end else if (par_complete_sig) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (par_q != LAST_PAR) begin
               par_d   = par_q + PAR_NUM_W'(1);
               state_d = S_FETCH;
            end else begin
               drain_load = 1'b1;
               state_d    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            drain_count = 1'b1;
            if (drain_expire) begin
               par_d = '0;
               if (phase_q == PHASE_SCATTER) begin
                  phase_d = PHASE_GATHER;
                  seen_d  = 1'b0;
                  state_d = S_FETCH;
               end else begin
                  iter_d = iter_inc;
                  if ((iter_inc == num_iter_q) || !seen_now) begin
                     conv_d  = !seen_now;
                     state_d = S_DONE;
                  end else begin
                     phase_d = PHASE_SCATTER;
                     state_d = S_FETCH;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         par_q      <= '0;
         phase_q    <= PHASE_SCATTER;
         num_iter_q <= '0;
         iter_q     <= '0;
         ws_q       <= '0;
         act_q      <= 1'b0;
         blank_q    <= 2'd0;
         seen_q     <= 1'b0;
         conv_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         par_q      <= par_d;
         phase_q    <= phase_d;
         num_iter_q <= num_iter_d;
         iter_q     <= iter_d;
         ws_q       <= ws_d;
         act_q      <= act_d;
         blank_q    <= blank_d;
         seen_q     <= seen_d;
         conv_q     <= conv_d;
      end
   end

   assign meta_par_id    = par_q;
   assign meta_phase     = phase_q;
   assign work_size      = ws_q;
   assign new_par_active = act_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign converged      = (state_q == S_DONE) && conv_q;
   assign iter_cnt       = iter_q;
   assign dbg_state      = state_q;

endmodule
